// File: rtl/shift_reg_unload.sv
// shift_reg_unload: parallel-in serial-out unloader, one BIT_WIDTH symbol per enabled cycle
//
// Parameters:
//   DIRECTION  "forward" emits slot 0 first, "reverse" emits slot SHIFT_LEN-1 first
//   SHIFT_LEN  symbols per word (>= 2)
//   BIT_WIDTH  bits per symbol (>= 1)
// Ports:
//   clk            rising-edge clock
//   in_ctr_Arst_n  asynchronous active-low reset
//   in_ctr_Srst    synchronous clear, active-high, beats load and en
//   in_ctr_load    load request for in
//   in_ctr_en      consumer advance / ready
//   in             parallel word, slot k = in[k*BIT_WIDTH +: BIT_WIDTH]
//   out            current symbol (registered)
//   out_valid      out holds a live symbol
//   out_last       out is the final symbol of the word
//   out_busy       a load would be refused this cycle
//   out_ovr        sticky refused-load flag, only with SHIFT_REG_UNLOAD_OVERRUN_EN defined
module shift_reg_unload #(
    parameter string DIRECTION = "forward",
    parameter int    SHIFT_LEN = 16,
    parameter int    BIT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           in_ctr_Arst_n,
    input  logic                           in_ctr_Srst,
    input  logic                           in_ctr_load,
    input  logic                           in_ctr_en,
    input  logic [SHIFT_LEN*BIT_WIDTH-1:0] in,
    output logic [BIT_WIDTH-1:0]           out,
    output logic                           out_valid,
    output logic                           out_last,
    output logic                           out_busy
`ifdef SHIFT_REG_UNLOAD_OVERRUN_EN
    ,
    output logic                           out_ovr
`endif
);
    localparam int CW = $clog2(SHIFT_LEN);
    localparam logic [CW-1:0] LAST = CW'(SHIFT_LEN - 1);
    localparam bit REV = (DIRECTION == "reverse");
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SHIFT_LEN*BIT_WIDTH-1:0] word, word_n;
    logic [BIT_WIDTH-1:0] out_n;
    logic accept;
    // Symbol presented at position idx of the emission order.
    function automatic logic [BIT_WIDTH-1:0] pick(input logic [SHIFT_LEN*BIT_WIDTH-1:0] w, input logic [CW-1:0] idx);
        int s;
        s = REV ? (SHIFT_LEN - 1 - int'(idx)) : int'(idx);
        return w[s*BIT_WIDTH +: BIT_WIDTH];
    endfunction
    assign out_valid = (state == SHIFT);
    assign out_last  = out_valid & (cnt == LAST);
    assign out_busy  = out_valid & ~(out_last & in_ctr_en);
    assign accept    = in_ctr_load & ~out_busy;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        word_n  = word;
        out_n   = out;
        if (accept) begin
            state_n = SHIFT;
            cnt_n   = '0;
            word_n  = in;
            out_n   = pick(in, '0);
        end else if (out_valid && in_ctr_en) begin
            state_n = out_last ? IDLE : SHIFT;
            cnt_n   = out_last ? '0 : cnt + 1'b1;
            out_n   = out_last ? '0 : pick(word, cnt + 1'b1);
        end
    end
    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
            out   <= '0;
        end else if (in_ctr_Srst) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
            out   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            word  <= word_n;
            out   <= out_n;
        end
    end
`ifdef SHIFT_REG_UNLOAD_OVERRUN_EN
    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n)
            out_ovr <= 1'b0;
        else if (in_ctr_Srst)
            out_ovr <= 1'b0;
        else if (in_ctr_load && out_busy)
            out_ovr <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_shift_reg_unload.sv
// tb_shift_reg_unload: scoreboard bench driving a forward and a reverse unloader in parallel
module tb_shift_reg_unload;
    localparam int SL = 16;
    localparam int BW = 4;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic srst = 1'b0;
    logic load = 1'b0;
    logic en = 1'b0;
    logic [SL*BW-1:0] din = '0;
    logic [BW-1:0] fo, ro;
    logic fv, fl, fb, rv, rl, rb;
`ifdef SHIFT_REG_UNLOAD_OVERRUN_EN
    logic fovr, rovr;
`endif
    int checks = 0;
    int failures = 0;
    logic [BW:0] qf[$];
    logic [BW:0] qr[$];
    logic [BW:0] ef, er;

    always #5 clk = ~clk;

    shift_reg_unload #(.DIRECTION("forward"), .SHIFT_LEN(SL), .BIT_WIDTH(BW)) u_fwd (
        .clk(clk), .in_ctr_Arst_n(arst_n), .in_ctr_Srst(srst), .in_ctr_load(load),
        .in_ctr_en(en), .in(din), .out(fo), .out_valid(fv), .out_last(fl), .out_busy(fb)
`ifdef SHIFT_REG_UNLOAD_OVERRUN_EN
        , .out_ovr(fovr)
`endif
    );

    shift_reg_unload #(.DIRECTION("reverse"), .SHIFT_LEN(SL), .BIT_WIDTH(BW)) u_rev (
        .clk(clk), .in_ctr_Arst_n(arst_n), .in_ctr_Srst(srst), .in_ctr_load(load),
        .in_ctr_en(en), .in(din), .out(ro), .out_valid(rv), .out_last(rl), .out_busy(rb)
`ifdef SHIFT_REG_UNLOAD_OVERRUN_EN
        , .out_ovr(rovr)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected stream of {last, symbol} for both emission orders.
    task automatic push(input logic [SL*BW-1:0] w);
        for (int k = 0; k < SL; k++) begin
            qf.push_back({(k == SL-1) ? 1'b1 : 1'b0, w[k*BW +: BW]});
            qr.push_back({(k == SL-1) ? 1'b1 : 1'b0, w[(SL-1-k)*BW +: BW]});
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_wait(input string name);
        int c;
        c = 0;
        while ((fv || rv) && c < 200) begin
            tick;
            c++;
        end
        chk(name, {63'd0, fv | rv}, 64'd0);
    endtask

    // A symbol is consumed at the edge where out_valid and en are both high.
    always @(negedge clk) begin
        if (arst_n && !srst) begin
            if (fv && en) begin
                if (qf.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fwd_extra actual=%0h required=none", {fl, fo});
                end else begin
                    ef = qf.pop_front();
                    chk("fwd_sym", {59'd0, fl, fo}, {59'd0, ef});
                end
            end
            if (rv && en) begin
                if (qr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rev_extra actual=%0h required=none", {rl, ro});
                end else begin
                    er = qr.pop_front();
                    chk("rev_sym", {59'd0, rl, ro}, {59'd0, er});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        tick;
        chk("rst_out", {60'd0, fo}, 64'd0);
        chk("rst_valid", {63'd0, fv | rv}, 64'd0);
        chk("rst_last", {63'd0, fl | rl}, 64'd0);
        chk("rst_busy", {63'd0, fb | rb}, 64'd0);
        arst_n = 1'b1;
        tick;
        // forward and reverse drain
        din = 64'hFEDCBA9876543210;
        push(din);
        load = 1'b1;
        en = 1'b1;
        tick;
        load = 1'b0;
        chk("first_fwd", {60'd0, fo}, 64'h0);
        chk("first_rev", {60'd0, ro}, 64'hF);
        chk("busy_mid", {63'd0, fb}, 64'd1);
        drain_wait("drain1_timeout");
        chk("drain1_out", {60'd0, fo}, 64'd0);
        chk("drain1_last", {63'd0, fl}, 64'd0);
        chk("drain1_q", 64'(qf.size() + qr.size()), 64'd0);
        // en while idle does nothing
        repeat (3) tick;
        chk("idle_en", {63'd0, fv | rv}, 64'd0);
        // stall pattern 1,0,0,1
        din = 64'h0F1E2D3C4B5A6978;
        push(din);
        load = 1'b1;
        tick;
        load = 1'b0;
        en = 1'b0;
        tick;
        chk("stall_hold", {59'd0, fv, fo}, {59'd0, 1'b1, 4'h8});
        begin
            int c;
            c = 0;
            while ((fv || rv) && c < 200) begin
                en = (c % 4 == 0) || (c % 4 == 3);
                tick;
                c++;
            end
            chk("stall_timeout", {63'd0, fv | rv}, 64'd0);
        end
        chk("stall_q", 64'(qf.size() + qr.size()), 64'd0);
        // back-to-back reload on the last symbol
        en = 1'b1;
        din = 64'hFEDCBA9876543210;
        push(din);
        push(64'h0123456789ABCDEF);
        load = 1'b1;
        tick;
        load = 1'b0;
        repeat (15) tick;
        chk("b2b_last", {63'd0, fl}, 64'd1);
        chk("b2b_busy", {63'd0, fb}, 64'd0);
        din = 64'h0123456789ABCDEF;
        load = 1'b1;
        tick;
        load = 1'b0;
        chk("b2b_valid", {63'd0, fv & rv}, 64'd1);
        chk("b2b_fwd", {60'd0, fo}, 64'hF);
        chk("b2b_rev", {60'd0, ro}, 64'h0);
        drain_wait("b2b_timeout");
        chk("b2b_q", 64'(qf.size() + qr.size()), 64'd0);
        // refused load at cnt=5
        din = 64'h89ABCDEF01234567;
        push(din);
        load = 1'b1;
        tick;
        load = 1'b0;
        repeat (5) tick;
        chk("ref_busy", {63'd0, fb}, 64'd1);
        din = 64'hFFFFFFFFFFFFFFFF;
        load = 1'b1;
        tick;
        load = 1'b0;
        chk("ref_next", {60'd0, fo}, 64'h1);
`ifdef SHIFT_REG_UNLOAD_OVERRUN_EN
        chk("ovr_set", {63'd0, fovr & rovr}, 64'd1);
`endif
        drain_wait("ref_timeout");
        chk("ref_q", 64'(qf.size() + qr.size()), 64'd0);
`ifdef SHIFT_REG_UNLOAD_OVERRUN_EN
        chk("ovr_sticky", {63'd0, fovr}, 64'd1);
        srst = 1'b1;
        tick;
        srst = 1'b0;
        chk("ovr_clr", {63'd0, fovr | rovr}, 64'd0);
`endif
        // sync clear at cnt=7
        din = 64'h13579BDF02468ACE;
        push(din);
        load = 1'b1;
        tick;
        load = 1'b0;
        repeat (7) tick;
        en = 1'b0;
        srst = 1'b1;
        tick;
        srst = 1'b0;
        qf.delete();
        qr.delete();
        chk("srst_valid", {63'd0, fv | rv}, 64'd0);
        chk("srst_out", {56'd0, fo, ro}, 64'd0);
        chk("srst_last", {63'd0, fl | rl}, 64'd0);
        en = 1'b1;
        // async reset between edges
        din = 64'h2468ACE013579BDF;
        push(din);
        load = 1'b1;
        tick;
        load = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, fv | rv}, 64'd0);
        chk("arst_out", {56'd0, fo, ro}, 64'd0);
        chk("arst_last", {63'd0, fl | rl}, 64'd0);
        qf.delete();
        qr.delete();
        tick;
        arst_n = 1'b1;
        tick;
        // clean restart after reset
        din = 64'hFEDCBA9876543210;
        push(din);
        load = 1'b1;
        tick;
        load = 1'b0;
        chk("restart_fwd", {60'd0, fo}, 64'h0);
        chk("restart_rev", {60'd0, ro}, 64'hF);
        drain_wait("restart_timeout");
        chk("restart_q", 64'(qf.size() + qr.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_reg_unload.md
Name: shift_reg_unload

Overview:
- Parallel-in, serial-out (PISO) counterpart of the `shift_reg` serial-in collector.
- Accepts one SHIFT_LEN×BIT_WIDTH word on a load strobe, then emits it one BIT_WIDTH symbol per enabled cycle.
- Provides valid and last flags, a busy indication, and back-to-back reload.
- Used to stream syndrome and error-location vectors from parallel BCH stages into symbol-serial stages.

Parameters:
- DIRECTION, "forward", emission order: "forward" emits slot 0 first; "reverse" emits slot SHIFT_LEN-1 first.
- SHIFT_LEN, 16, symbols per word (≥2).
- BIT_WIDTH, 4, bits per symbol (≥1).

Ports:
- clk  input  1  rising-edge clock
- in_ctr_Arst_n  input  1  asynchronous active-low reset
- in_ctr_Srst  input  1  synchronous clear, active-high
- in_ctr_load  input  1  load request for `in`
- in_ctr_en  input  1  consumer advance / ready
- in  input  SHIFT_LEN*BIT_WIDTH  parallel word; slot k = in[k*BIT_WIDTH +: BIT_WIDTH]
- out  output  BIT_WIDTH  current symbol, registered
- out_valid  output  1  out holds a live symbol
- out_last  output  1  out is the final symbol of the word
- out_busy  output  1  a load would be refused this cycle

Behaviour:
- Async reset (in_ctr_Arst_n=0):
  - Takes effect immediately, regardless of clk.
  - Clears out=0, out_valid=0, out_last=0, symbol counter=0, internal word=0; state IDLE.
- Sync clear (in_ctr_Srst=1 at an edge):
  - Same clear as async reset.
  - Has priority over load and en, including mid-word; the partially emitted word is discarded.
- States:
  - IDLE: out_valid=0.
  - SHIFT: out_valid=1; counter cnt = 0..SHIFT_LEN-1 indexes the symbol on out.
- Load acceptance:
  - Accepted when in_ctr_load=1 and (state=IDLE, or state=SHIFT with cnt=SHIFT_LEN-1 and in_ctr_en=1).
  - On acceptance: `in` is captured into the internal word; cnt=0; out=first symbol; out_valid=1.
  - The first symbol is visible one cycle after the load edge (latency 1).
- Emission order:
  - Forward: out = slot cnt.
  - Reverse: out = slot SHIFT_LEN-1-cnt.
- Advance:
  - In SHIFT with in_ctr_en=1 and cnt<SHIFT_LEN-1: cnt increments and out takes the next symbol.
  - With in_ctr_en=0: out, cnt and flags hold (stall).
- End of word:
  - In SHIFT with cnt=SHIFT_LEN-1 and in_ctr_en=1, with no simultaneous accepted load: go to IDLE, out=0, out_valid=0.
  - With a simultaneous load: reload, no bubble.
- Flags:
  - out_last = out_valid & (cnt==SHIFT_LEN-1).
  - out_busy = out_valid & ~(out_last & in_ctr_en); combinational from state and in_ctr_en.
- Refused loads: a load while busy is ignored; the word and counter are unaffected.
- Idle advance: in_ctr_en in IDLE has no effect.
- Word length: exactly SHIFT_LEN symbols are emitted per accepted load, never more or fewer.
- Counter width: $clog2(SHIFT_LEN); with SHIFT_LEN a power of two it never wraps past SHIFT_LEN-1.

Optional Feature:
- Macro: SHIFT_REG_UNLOAD_OVERRUN_EN.
- When defined:
  - Adds output out_ovr (1 bit), a sticky flag.
  - Set at the edge where in_ctr_load=1 while out_busy=1.
  - Cleared only by async reset or in_ctr_Srst.
  - The refused load is still ignored.
- When undefined: the port is absent and refused loads are silently dropped.

Test Plan:
- Forward drain: load in=64'hFEDCBA9876543210, en held high → out 0,1,2,…,F on 16 consecutive cycles; out_last only with F; then out_valid=0, out=0.
- Reverse drain: same load with DIRECTION="reverse" → out F,E,…,0; out_last with 0.
- Stall: forward load, en toggled 1,0,0,1… → each symbol held while en=0; still exactly 16 symbols, in order.
- Back-to-back: load word A, then assert load with word 64'h0123456789ABCDEF on A's last symbol with en=1 → next cycle out=F (forward slot 0), out_valid stays 1, no bubble.
- Refused load / overrun: load at cnt=5 → ignored, drain continues with 6; with SHIFT_REG_UNLOAD_OVERRUN_EN, out_ovr=1 until in_ctr_Srst.
- Resets mid-word:
  - in_ctr_Srst at cnt=7 → next cycle IDLE, all outputs 0.
  - in_ctr_Arst_n low between edges → outputs 0 immediately.
  - After release, a new load starts cleanly at slot 0.
